// File: rtl/hazard_controller_if.sv
// Decode/branch inputs and stall/flush/forward outputs of the hazard controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface hazard_controller_if;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_uses_rt;
  logic [4:0]  d_dst;
  logic        d_regwrite;
  logic        d_memread;
  logic        m_pc_src;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_exmem;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output d_valid, d_rs, d_rt, d_uses_rt, d_dst, d_regwrite, d_memread, m_pc_src,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
    input  fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_uses_rt, d_dst, d_regwrite, d_memread, m_pc_src,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
    output fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard unit: load-use stall, branch flush and EX operand
// forwarding, driven from a shadow scoreboard of the EX, MEM and WB stages.
module hazard_controller #(
  parameter logic [15:0] CNT_RESET = 16'h0000  // reset value of both performance counters
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } slot_t;

  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [4:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic        ex_uses_rt_q, ex_uses_rt_d;
  logic [15:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  logic        load_use, flush, stall;

  // Nearest older producer wins; $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input slot_t mem_s,
                                         input slot_t wb_s);
    if (src != 5'd0 && mem_s.valid && mem_s.regwrite && mem_s.dst == src) return 2'b10;
    if (src != 5'd0 && wb_s.valid && wb_s.regwrite && wb_s.dst == src)    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    load_use = ex_q.valid && ex_q.memread && (ex_q.dst != 5'd0) && hz.d_valid &&
               ((ex_q.dst == hz.d_rs) || (hz.d_uses_rt && (ex_q.dst == hz.d_rt)));
    flush    = hz.m_pc_src && !rst;
    stall    = load_use && !flush && !rst;

    wb_d  = mem_q;
    mem_d = flush ? slot_t'('0) : ex_q;

    ex_d         = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_uses_rt_d = 1'b0;
    if (!flush && !stall) begin
      ex_d.valid    = hz.d_valid;
      ex_d.dst      = hz.d_dst;
      ex_d.regwrite = hz.d_regwrite;
      ex_d.memread  = hz.d_memread;
      ex_rs_d       = hz.d_rs;
      ex_rt_d       = hz.d_rt;
      ex_uses_rt_d  = hz.d_uses_rt;
    end

    stall_count_d = stall_count_q;
    if (stall && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    flush_count_d = flush_count_q;
    if (flush && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_uses_rt_q  <= 1'b0;
      stall_count_q <= CNT_RESET;
      flush_count_q <= CNT_RESET;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_uses_rt_q  <= ex_uses_rt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.pc_write    = !stall;
  assign hz.ifid_write  = !stall;
  assign hz.idex_bubble = stall;
  assign hz.flush_ifid  = flush;
  assign hz.flush_idex  = flush;
  assign hz.flush_exmem = flush;
  assign hz.fwd_a       = ex_q.valid ? fwd_sel(ex_rs_q, mem_q, wb_q) : 2'b00;
  assign hz.fwd_b       = (ex_q.valid && ex_uses_rt_q) ? fwd_sel(ex_rt_q, mem_q, wb_q) : 2'b00;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against an instruction-level
// pipeline model; a second instance with preset counters exercises saturation.
module tb_hazard_controller;
  localparam logic [15:0] PRESET = 16'hFFF0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ut;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if hif ();
  hazard_controller_if sif ();
  assign sif.d_valid    = hif.d_valid;
  assign sif.d_rs       = hif.d_rs;
  assign sif.d_rt       = hif.d_rt;
  assign sif.d_uses_rt  = hif.d_uses_rt;
  assign sif.d_dst      = hif.d_dst;
  assign sif.d_regwrite = hif.d_regwrite;
  assign sif.d_memread  = hif.d_memread;
  assign sif.m_pc_src   = hif.m_pc_src;

  hazard_controller dut (.clk(clk), .rst(rst), .hz(hif));
  hazard_controller #(.CNT_RESET(PRESET)) dut_sat (.clk(clk), .rst(rst), .hz(sif));

  // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  ins_t pipe [3];
  int   sc = 0;
  int   fc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  localparam ins_t NOP = '0;

  function automatic ins_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic ut,
                              logic [4:0] dst, logic rw, logic mr);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.ut = ut; i.dst = dst; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.v   = ($urandom % 8) != 0;
    i.rs  = 5'($urandom_range(0, 3));
    i.rt  = 5'($urandom_range(0, 3));
    i.ut  = 1'($urandom % 2);
    i.dst = 5'($urandom_range(0, 3));
    i.mr  = ($urandom % 3) == 0;
    i.rw  = i.mr ? 1'b1 : 1'($urandom % 2);
    return i;
  endfunction

  function automatic logic [15:0] sat16(int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  function automatic logic ref_load_use(ins_t d);
    ins_t e;
    e = pipe[0];
    return d.v && e.v && e.mr && e.dst != 0 && (e.dst == d.rs || (d.ut && e.dst == d.rt));
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] src);
    for (int k = 1; k < 3; k++)
      if (src != 0 && pipe[k].v && pipe[k].rw && pipe[k].dst == src)
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(ins_t d, logic pcsrc);
    hif.d_valid    = d.v;
    hif.d_rs       = d.rs;
    hif.d_rt       = d.rt;
    hif.d_uses_rt  = d.ut;
    hif.d_dst      = d.dst;
    hif.d_regwrite = d.rw;
    hif.d_memread  = d.mr;
    hif.m_pc_src   = pcsrc;
  endtask

  task automatic drive_check(ins_t d, logic pcsrc);
    logic st;
    logic [1:0] fa, fb;
    @(negedge clk);
    drive(d, pcsrc);
    #1;
    st = ref_load_use(d) && !pcsrc;
    fa = pipe[0].v ? ref_fwd(pipe[0].rs) : 2'b00;
    fb = (pipe[0].v && pipe[0].ut) ? ref_fwd(pipe[0].rt) : 2'b00;
    $display("txn v=%0b rs=%0d rt=%0d ut=%0b dst=%0d rw=%0b mr=%0b pcsrc=%0b stall=%0b fwd=%0b/%0b",
             d.v, d.rs, d.rt, d.ut, d.dst, d.rw, d.mr, pcsrc, st, fa, fb);
    chk("pc_write", 16'(hif.pc_write), 16'(!st));
    chk("ifid_write", 16'(hif.ifid_write), 16'(!st));
    chk("idex_bubble", 16'(hif.idex_bubble), 16'(st));
    chk("flush_ifid", 16'(hif.flush_ifid), 16'(pcsrc));
    chk("flush_idex", 16'(hif.flush_idex), 16'(pcsrc));
    chk("flush_exmem", 16'(hif.flush_exmem), 16'(pcsrc));
    chk("fwd_a", 16'(hif.fwd_a), 16'(fa));
    chk("fwd_b", 16'(hif.fwd_b), 16'(fb));
    chk("stall_count", hif.stall_count, sat16(sc));
    chk("flush_count", hif.flush_count, sat16(fc));
    chk("sat_stall_count", sif.stall_count, sat16(sc + int'(PRESET)));
    chk("sat_flush_count", sif.flush_count, sat16(fc + int'(PRESET)));
  endtask

  task automatic advance(ins_t d, logic pcsrc);
    logic st;
    st = ref_load_use(d) && !pcsrc;
    pipe[2] = pipe[1];
    if (pcsrc) begin
      pipe[1] = NOP;
      pipe[0] = NOP;
      fc++;
    end else if (st) begin
      pipe[1] = pipe[0];
      pipe[0] = NOP;
      sc++;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = d;
    end
  endtask

  task automatic step(ins_t d, logic pcsrc);
    drive_check(d, pcsrc);
    advance(d, pcsrc);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_pc_write"}, 16'(hif.pc_write), 16'd1);
    chk({tag, "_ifid_write"}, 16'(hif.ifid_write), 16'd1);
    chk({tag, "_bubble"}, 16'(hif.idex_bubble), 16'd0);
    chk({tag, "_flushes"}, 16'({hif.flush_ifid, hif.flush_idex, hif.flush_exmem}), 16'd0);
    chk({tag, "_fwd"}, 16'({hif.fwd_a, hif.fwd_b}), 16'd0);
    chk({tag, "_stall_count"}, hif.stall_count, 16'd0);
    chk({tag, "_flush_count"}, hif.flush_count, 16'd0);
    chk({tag, "_sat_counts"}, sif.stall_count & sif.flush_count, PRESET);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = NOP;
    sc = 0;
    fc = 0;
  endtask

  initial begin
    ins_t lw1, add3, addi10, add10, addi12, add12, lw0, add300;
    lw1    = mk(1, 0, 0, 0, 1, 1, 1);
    add3   = mk(1, 1, 2, 1, 3, 1, 0);
    addi10 = mk(1, 0, 0, 0, 10, 1, 0);
    add10  = mk(1, 10, 11, 1, 10, 1, 0);
    addi12 = mk(1, 0, 0, 0, 12, 1, 0);
    add12  = mk(1, 12, 12, 1, 12, 1, 0);
    lw0    = mk(1, 0, 0, 0, 0, 1, 1);
    add300 = mk(1, 0, 0, 1, 3, 1, 0);
    model_clear();

    // Reset holds outputs regardless of a branch and a would-be hazard on the inputs.
    drive(add3, 1'b1);
    #12;
    check_reset_vals("reset");
    drive(NOP, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    advance(NOP, 1'b0);

    // lw $1 ; add $3,$1,$2 : one stall, then WB forward.
    step(lw1, 1'b0);
    drive_check(add3, 1'b0);
    chk("r031_pc_write", 16'(hif.pc_write), 16'd0);
    chk("r031_bubble", 16'(hif.idex_bubble), 16'd1);
    advance(add3, 1'b0);
    step(add3, 1'b0);
    drive_check(NOP, 1'b0);
    chk("r031_fwd_a", 16'(hif.fwd_a), 16'b01);
    chk("r031_stall_count", hif.stall_count, 16'd1);
    advance(NOP, 1'b0);

    // addi $10 ; add $10,$10,$11 : MEM forward on rs only.
    step(addi10, 1'b0);
    step(add10, 1'b0);
    drive_check(NOP, 1'b0);
    chk("r032_fwd", 16'({hif.fwd_a, hif.fwd_b}), 16'b1000);
    advance(NOP, 1'b0);

    // addi $12 two slots ahead, then back-to-back producers.
    step(addi12, 1'b0);
    step(NOP, 1'b0);
    step(add12, 1'b0);
    drive_check(NOP, 1'b0);
    chk("r033_fwd_wb", 16'({hif.fwd_a, hif.fwd_b}), 16'b0101);
    advance(NOP, 1'b0);
    step(addi12, 1'b0);
    step(addi12, 1'b0);
    step(add12, 1'b0);
    drive_check(NOP, 1'b0);
    chk("r033_fwd_mem", 16'({hif.fwd_a, hif.fwd_b}), 16'b1010);
    advance(NOP, 1'b0);

    // Branch flush wins over a simultaneous load-use stall.
    step(lw1, 1'b0);
    drive_check(add3, 1'b1);
    chk("r034_flushes", 16'({hif.flush_ifid, hif.flush_idex, hif.flush_exmem}), 16'b111);
    chk("r034_pc_write", 16'(hif.pc_write), 16'd1);
    chk("r034_bubble", 16'(hif.idex_bubble), 16'd0);
    advance(add3, 1'b1);
    drive_check(NOP, 1'b0);
    chk("r034_flush_count", hif.flush_count, 16'd1);
    chk("r034_stall_count", hif.stall_count, 16'd1);
    advance(NOP, 1'b0);

    // Loads into $0 never stall or forward.
    step(lw0, 1'b0);
    drive_check(add300, 1'b0);
    chk("r035_no_stall", 16'(hif.idex_bubble), 16'd0);
    advance(add300, 1'b0);
    drive_check(NOP, 1'b0);
    chk("r035_fwd", 16'({hif.fwd_a, hif.fwd_b}), 16'd0);
    advance(NOP, 1'b0);

    // Push the preset instance's stall counter into saturation.
    for (int i = 0; i < 16; i++) begin
      step(lw1, 1'b0);
      step(add3, 1'b0);
      step(add3, 1'b0);
    end
    drive_check(NOP, 1'b0);
    chk("r035_sat_stall", sif.stall_count, 16'hFFFF);
    advance(NOP, 1'b0);

    // Reset pulsed in the middle of a stall.
    step(lw1, 1'b0);
    drive_check(add3, 1'b0);
    chk("r036_stalling", 16'(hif.idex_bubble), 16'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("r036");
    model_clear();
    drive(NOP, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    advance(NOP, 1'b0);
    drive_check(add3, 1'b0);
    chk("r036_empty", 16'(hif.pc_write), 16'd1);
    advance(add3, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) step(rand_ins(), ($urandom % 8) == 0);
    drive_check(NOP, 1'b0);
    chk("rand_sat_stall", sif.stall_count, 16'hFFFF);
    advance(NOP, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clk  in  1  pipeline clock, rising-edge active.
REQ-002 rst  in  1  asynchronous reset, active-high.
REQ-003 d_valid  in  1  decode stage holds a real instruction (0 = nop or bubble).
REQ-004 d_rs, d_rt  in  5 each  decode-stage source register fields (inst[25:21], inst[20:16]).
REQ-005 d_uses_rt  in  1  decode instruction reads rt (R-type, beq, sw = 1; addi, lw = 0).
REQ-006 d_dst  in  5  decode instruction's resolved destination (rd if regdst, else rt).
REQ-007 d_regwrite, d_memread  in  1 each  decode control bits.
REQ-008 m_pc_src  in  1  taken branch resolved in MEM this cycle.
REQ-009 pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers.
REQ-010 idex_bubble  out  1  load zeros (nop) into ID/EX this edge.
REQ-011 flush_ifid, flush_idex, flush_exmem  out  1 each  squash the named pipe register this edge.
REQ-012 fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 EX/MEM alures, 01 MEM/WB writeback data.
REQ-013 stall_count, flush_count  out  16 each  performance counters.

Function
REQ-014 The block SHALL keep a shadow scoreboard of three slots (EX, MEM, WB); each slot holds valid, dst[4:0], regwrite, memread, and the EX slot also holds rs[4:0], rt[4:0], uses_rt.
REQ-015 On each clk edge, in normal flow, the WB slot SHALL take the MEM slot, the MEM slot SHALL take the EX slot, and the EX slot SHALL take the decode inputs, with valid = d_valid.
REQ-016 Load-use hazard: raise load_use when all of the following hold:
 - EX slot valid, memread = 1, dst != 0;
 - dst == d_rs, or (d_uses_rt and dst == d_rt);
 - d_valid = 1.
REQ-017 While load_use = 1 and m_pc_src = 0, the block SHALL drive:
 - pc_write = 0, ifid_write = 0, idex_bubble = 1;
 - at the edge, EX slot valid = 0, while MEM and WB advance normally.
REQ-018 While m_pc_src = 1, the block SHALL drive:
 - flush_ifid = flush_idex = flush_exmem = 1;
 - pc_write = 1, ifid_write = 1, idex_bubble = 0;
 - at the edge, EX and MEM slots valid = 0 and WB takes the old MEM slot.
REQ-019 A flush SHALL take priority over a stall in the same cycle; the stall is dropped and is not counted.
REQ-020 Otherwise pc_write = ifid_write = 1 and idex_bubble = all flushes = 0.
REQ-021 The stall, bubble and flush outputs SHALL be combinational from the scoreboard state and current inputs (zero-latency).
REQ-022 fwd_a for the EX-slot instruction SHALL be selected by the first matching rule:
 - 10 if MEM slot valid, regwrite = 1, dst != 0 and dst == EX.rs;
 - else 01 if WB slot valid, regwrite = 1, dst != 0 and dst == EX.rs;
 - else 00.
 - fwd_a SHALL be 00 when the EX slot is invalid.
REQ-023 fwd_b SHALL follow the same rules using EX.rt, and SHALL be 00 when EX.uses_rt = 0.
REQ-024 Register 0 SHALL never be forwarded and never cause a stall.
REQ-025 stall_count SHALL increment on every edge where REQ-017 applies.
REQ-026 flush_count SHALL increment on every edge where m_pc_src = 1.
REQ-027 Both counters SHALL saturate at 16'hFFFF (no wrap).
REQ-028 Consecutive stalls SHALL NOT occur for a single load, since the bubble clears the hazard in the following cycle.

Reset
REQ-029 While rst = 1, all outputs SHALL hold these values, independent of the inputs:
 - all scoreboard valids = 0; stall_count = flush_count = 0;
 - pc_write = ifid_write = 1;
 - idex_bubble = 0, all flushes = 0, fwd_a = fwd_b = 00.
REQ-030 Reset asserted mid-stall or mid-flush SHALL take effect immediately, with no pending action after release.

Verification
REQ-031 lw $1,0($0) then add $3,$1,$2 → one cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_count = 1; next cycle add in EX with fwd_a = 01.
REQ-032 addi $10,$0,5 then add $10,$10,$11 → no stall; add in EX sees fwd_a = 10, fwd_b = 00.
REQ-033 add $12,$12,$12 two slots after addi $12 → fwd_a = fwd_b = 01; when both MEM and WB match $12, fwd = 10.
REQ-034 m_pc_src = 1 in the same cycle as a load_use condition → all flushes = 1, pc_write = 1, idex_bubble = 0; flush_count +1, stall_count unchanged.
REQ-035 Writes to $0 (lw $0 then add $3,$0,$0) → no stall, fwd = 00; stall_count preset near saturation (65535 stalls) stays at 16'hFFFF.
REQ-036 rst pulsed during a stall → outputs return to the reset values immediately, and the scoreboard is empty after release.
